// File: rtl/serial_match_counter_pkg.sv
// Shared state encoding and parameter legality helper for serial_match_counter.
package serial_match_counter_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    // True when the parameter pair is legal: 1 <= width <= 64 and 2**cnt_bits > width.
    function automatic bit cnt_bits_ok(input int unsigned width, input int unsigned cnt_bits);
        if (width < 1 || width > 64) begin
            return 1'b0;
        end
        if (cnt_bits >= 31) begin
            return 1'b1;
        end
        return (32'd1 << cnt_bits) > width;
    endfunction

endpackage

// File: rtl/match_bit_cell.sv
// Single-bit compare cell: optional input inversion followed by XNOR.
module match_bit_cell #(
    parameter logic [1:0] InvertMask = 2'b00
) (
    input  logic bit_a,
    input  logic bit_b,
    output logic match
);

    assign match = ~((bit_a ^ InvertMask[0]) ^ (bit_b ^ InvertMask[1]));

endmodule

// File: rtl/serial_match_counter.sv
// Bit-serial word compare: accumulates an all-equal flag and a matching-bit count
// over WIDTH bit pairs, then pulses done for one cycle.
module serial_match_counter
    import serial_match_counter_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned CNT_BITS   = 4,
    parameter logic [1:0]  InvertMask = 2'b00
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                start,
    input  logic                bit_valid,
    input  logic                bit_a,
    input  logic                bit_b,
    output logic                busy,
    output logic                done,
    output logic                equal,
    output logic [CNT_BITS-1:0] match_count
);

    localparam int unsigned IdxBits = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IdxBits-1:0] LastIdx = IdxBits'(WIDTH - 1);

    if (!cnt_bits_ok(WIDTH, CNT_BITS)) begin : gen_bad_params
        $error("serial_match_counter: illegal WIDTH/CNT_BITS combination");
    end

    state_e              state_q, state_d;
    logic [IdxBits-1:0]  idx_q, idx_d;
    logic [CNT_BITS-1:0] run_cnt_q, run_cnt_d;
    logic                acc_q, acc_d;
    logic                equal_q, equal_d;
    logic [CNT_BITS-1:0] count_q, count_d;
    logic                match;

    match_bit_cell #(
        .InvertMask(InvertMask)
    ) u_match_bit_cell (
        .bit_a(bit_a),
        .bit_b(bit_b),
        .match(match)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        run_cnt_d = run_cnt_q;
        acc_d     = acc_q;
        equal_d   = equal_q;
        count_d   = count_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StShift;
                    idx_d     = '0;
                    run_cnt_d = '0;
                    acc_d     = 1'b1;
                end
            end
            StShift: begin
                if (bit_valid) begin
                    run_cnt_d = run_cnt_q + CNT_BITS'(match);
                    acc_d     = acc_q & match;
                    if (idx_q == LastIdx) begin
                        // Results publish on the same edge that samples the last bit.
                        state_d = StDone;
                        idx_d   = '0;
                        equal_d = acc_q & match;
                        count_d = run_cnt_q + CNT_BITS'(match);
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            run_cnt_q <= '0;
            acc_q     <= 1'b1;
            equal_q   <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            run_cnt_q <= run_cnt_d;
            acc_q     <= acc_d;
            equal_q   <= equal_d;
            count_q   <= count_d;
        end
    end

    assign busy        = (state_q == StShift);
    assign done        = (state_q == StDone);
    assign equal       = equal_q;
    assign match_count = count_q;

endmodule

// File: tb/tb_serial_match_counter.sv
// Randomized self-checking bench for serial_match_counter, three inversion variants in parallel.
module tb_serial_match_counter;

    localparam int unsigned W  = 8;
    localparam int unsigned CB = 4;

    logic clock = 1'b0;
    logic reset_n;
    logic start;
    logic bit_valid;
    logic bit_a;
    logic bit_b;

    logic          busy  [3];
    logic          done  [3];
    logic          equal [3];
    logic [CB-1:0] cnt   [3];

    logic          exp_eq  [3];
    logic [CB-1:0] exp_cnt [3];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    serial_match_counter #(.WIDTH(W), .CNT_BITS(CB), .InvertMask(2'b00)) u_dut0 (
        .clock(clock), .reset_n(reset_n), .start(start), .bit_valid(bit_valid),
        .bit_a(bit_a), .bit_b(bit_b), .busy(busy[0]), .done(done[0]),
        .equal(equal[0]), .match_count(cnt[0])
    );

    serial_match_counter #(.WIDTH(W), .CNT_BITS(CB), .InvertMask(2'b01)) u_dut1 (
        .clock(clock), .reset_n(reset_n), .start(start), .bit_valid(bit_valid),
        .bit_a(bit_a), .bit_b(bit_b), .busy(busy[1]), .done(done[1]),
        .equal(equal[1]), .match_count(cnt[1])
    );

    serial_match_counter #(.WIDTH(W), .CNT_BITS(CB), .InvertMask(2'b11)) u_dut3 (
        .clock(clock), .reset_n(reset_n), .start(start), .bit_valid(bit_valid),
        .bit_a(bit_a), .bit_b(bit_b), .busy(busy[2]), .done(done[2]),
        .equal(equal[2]), .match_count(cnt[2])
    );

    function automatic logic [1:0] mask_of(input int k);
        case (k)
            0:       return 2'b00;
            1:       return 2'b01;
            default: return 2'b11;
        endcase
    endfunction

    // Reference: count of positions where the (possibly inverted) operands agree.
    function automatic logic [CB-1:0] ref_count(input int k, input logic [W-1:0] a,
                                                input logic [W-1:0] b);
        logic [1:0]   m;
        logic [W-1:0] ea;
        logic [W-1:0] eb;
        m  = mask_of(k);
        ea = a ^ {W{m[0]}};
        eb = b ^ {W{m[1]}};
        return CB'($countones(~(ea ^ eb)));
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic eb, input logic ed);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s/m%0d/busy", tag, k), 32'(busy[k]), 32'(eb));
            check($sformatf("%s/m%0d/done", tag, k), 32'(done[k]), 32'(ed));
            check($sformatf("%s/m%0d/equal", tag, k), 32'(equal[k]), 32'(exp_eq[k]));
            check($sformatf("%s/m%0d/count", tag, k), 32'(cnt[k]), 32'(exp_cnt[k]));
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic rand_bits();
        bit_a = 1'($urandom);
        bit_b = 1'($urandom);
    endtask

    // One full word; gaps of gap_len cycles precede bit index gap_pos (-1 for none).
    task automatic run_word(input logic [W-1:0] a, input logic [W-1:0] b, input int gap_pos,
                            input int gap_len, input bit noisy, input bit rand_gaps);
        int ng;
        start     = 1'b1;
        bit_valid = noisy;
        rand_bits();
        step();
        check_all("start", 1'b1, 1'b0);
        for (int i = 0; i < int'(W); i++) begin
            ng = (i == gap_pos) ? gap_len : 0;
            if (rand_gaps && $urandom_range(0, 3) == 0) ng = int'($urandom_range(1, 3));
            for (int g = 0; g < ng; g++) begin
                bit_valid = 1'b0;
                start     = noisy ? 1'($urandom) : 1'b0;
                rand_bits();
                step();
                check_all("gap", 1'b1, 1'b0);
            end
            bit_valid = 1'b1;
            bit_a     = a[i];
            bit_b     = b[i];
            start     = noisy ? 1'($urandom) : 1'b0;
            step();
            if (i == int'(W) - 1) begin
                for (int k = 0; k < 3; k++) begin
                    exp_cnt[k] = ref_count(k, a, b);
                    exp_eq[k]  = (exp_cnt[k] == CB'(W));
                end
                check_all("done", 1'b0, 1'b1);
            end else begin
                check_all("bit", 1'b1, 1'b0);
            end
        end
        start     = noisy;
        bit_valid = noisy;
        rand_bits();
        step();
        check_all("after", 1'b0, 1'b0);
        start     = 1'b0;
        bit_valid = 1'b0;
        step();
        check_all("idle", 1'b0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        bit_valid = 1'b0;
        bit_a     = 1'b0;
        bit_b     = 1'b0;
        for (int k = 0; k < 3; k++) begin
            exp_eq[k]  = 1'b0;
            exp_cnt[k] = '0;
        end

        // Reset held with random inputs.
        for (int c = 0; c < 3; c++) begin
            start     = 1'($urandom);
            bit_valid = 1'($urandom);
            rand_bits();
            step();
            check_all("reset", 1'b0, 1'b0);
        end
        start     = 1'b0;
        bit_valid = 1'b0;
        reset_n   = 1'b1;
        step();
        check_all("post_reset", 1'b0, 1'b0);
        step();
        check_all("post_reset2", 1'b0, 1'b0);

        run_word(8'hA5, 8'hA5, -1, 0, 1'b0, 1'b0);
        run_word(8'hA5, 8'h5A, -1, 0, 1'b0, 1'b0);
        run_word(8'hFF, 8'hFE, 3, 3, 1'b0, 1'b0);
        run_word(8'h0F, 8'h0F, -1, 0, 1'b1, 1'b0);
        run_word(8'h00, 8'hFF, -1, 0, 1'b0, 1'b0);

        // Abort mid-word with an asynchronous reset.
        start = 1'b1;
        step();
        start = 1'b0;
        check_all("abort_start", 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            bit_valid = 1'b1;
            rand_bits();
            step();
            check_all("abort_bit", 1'b1, 1'b0);
        end
        #2;
        reset_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            exp_eq[k]  = 1'b0;
            exp_cnt[k] = '0;
        end
        check_all("abort_async", 1'b0, 1'b0);
        for (int c = 0; c < 2; c++) begin
            bit_valid = 1'($urandom);
            rand_bits();
            step();
            check_all("abort_hold", 1'b0, 1'b0);
        end
        bit_valid = 1'b0;
        reset_n   = 1'b1;
        step();
        check_all("abort_release", 1'b0, 1'b0);
        run_word(8'h33, 8'h30, -1, 0, 1'b0, 1'b0);

        for (int n = 0; n < 25; n++) begin
            run_word(W'($urandom), W'($urandom), -1, 0, 1'($urandom), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_match_counter.md
Name: serial_match_counter

Overview:
- Bit-serial equality and similarity stage that sits directly downstream of the two-input XNOR cell.
- Consumes one pair of operand bits per valid cycle and forms the per-bit match, ~(a ^ b), after optional input inversion.
- Over a WIDTH-bit word it accumulates an all-bits-equal flag and a count of matching bit positions (WIDTH minus Hamming distance).
- Results feed the CPU's compare and branch-condition logic, which waits for a one-cycle done pulse.

Parameters:
- WIDTH, default 8: number of bit pairs per word; legal range 1..64.
- CNT_BITS, default 4: width of match_count; must satisfy 2**CNT_BITS > WIDTH.
- InvertMask, default 2'b00: bit0 = 1 inverts bit_a before compare; bit1 = 1 inverts bit_b before compare.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a new word; sampled only in IDLE.
- bit_valid  input  1  bit_a and bit_b are valid this cycle; sampled only in SHIFT.
- bit_a  input  1  serial operand A, LSB first.
- bit_b  input  1  serial operand B, LSB first.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse when the result is valid.
- equal  output  1  1 if all WIDTH bit pairs matched.
- match_count  output  CNT_BITS  number of matching bit positions.

Behaviour:
- Clocking and reset: one clock (clock). reset_n is asynchronous and active-low.
- While reset_n = 0:
  - state = IDLE.
  - busy, done and equal = 0; match_count = 0.
  - Internal bit index = 0, running count = 0, equality accumulator = 1.
- Reset asserted mid-word: aborts at once. No done is produced and partial results are discarded.
- Match bit: m = ~(a' ^ b'), where a' = bit_a ^ InvertMask[0] and b' = bit_b ^ InvertMask[1].
- IDLE:
  - start = 1 → SHIFT; index = 0, running count = 0, accumulator = 1.
  - bit_valid is ignored in IDLE, including in the cycle start is taken. The first bit is sampled no earlier than the cycle after start.
  - equal and match_count keep holding the last word's result.
- SHIFT:
  - busy = 1.
  - Each cycle with bit_valid = 1: running count += m, accumulator &= m, index += 1.
  - Cycles with bit_valid = 0 hold all state; gaps of any length are legal.
  - start is ignored in SHIFT.
  - When the bit with index == WIDTH-1 is sampled → DONE. On that same edge, equal <= final accumulator and match_count <= final count.
- DONE:
  - Lasts exactly one cycle: done = 1, busy = 0, then → IDLE unconditionally.
  - start is ignored in DONE and must be re-presented in IDLE.
- Latency: done is high in the cycle after the edge that samples the last valid bit. With contiguous bits, start at cycle t gives bits at t+1..t+WIDTH and done at t+WIDTH+1.
- Width rules:
  - Running count saturation is impossible given the CNT_BITS constraint.
  - The index counter is wide enough to hold WIDTH-1 and never wraps within a word.
- Output stability: equal and match_count change only on the SHIFT→DONE edge or on reset. They are stable during SHIFT of the following word.

Decomposition:
- Shared package holds:
  - State encoding constants: IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2. Encoding 2'd3 is illegal and recovers to IDLE.
  - The CNT_BITS legality check helper.
- One sub-module is natural: match_bit_cell.
  - Purely combinational: applies InvertMask and produces m.
  - Instantiated once and keeps the compare function identical to the upstream gate cell.
- FSM, counters and result registers stay in serial_match_counter.

Test Plan:
- Reset: hold reset_n = 0 with random inputs → busy = 0, done = 0, equal = 0, match_count = 0. Release reset → all outputs stay 0 and state is IDLE.
- Equal words: WIDTH = 8, start, then A = 0xA5 and B = 0xA5 on 8 contiguous valid cycles → done pulses for one cycle at t+9, equal = 1, match_count = 8, busy low on the done cycle.
- Fully different words: A = 0xA5, B = 0x5A, contiguous → equal = 0, match_count = 0. Then A = 0xFF, B = 0xFE with bit_valid low for 3 cycles after bit 2 → busy stays 1 through the gap, done only after the 8th valid bit, equal = 0, match_count = 7.
- Ignored controls: pulse start during SHIFT and during DONE; drive bit_valid in IDLE together with start → none of these alters the result. A = 0x0F, B = 0x0F still gives equal = 1, match_count = 8, with exactly one done pulse.
- Reset mid-word: drop reset_n after 4 valid bits → busy = 0 and outputs = 0 immediately (asynchronous), no done. Next full word A = 0x33, B = 0x30 → equal = 0, match_count = 6.
- Inversion: InvertMask = 2'b01, A = 0x00, B = 0xFF → equal = 1, match_count = 8. InvertMask = 2'b11, A = 0x0F, B = 0x0F → equal = 1, match_count = 8.
